wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline boundary: consumes the registered WB-stage signals and commits the result into the 32x32 general-purpose register file.
- Selects the write-back value from ALU result, load data, link address, HI, LO or CP0 data.
- Provides two combinational read ports to the decode stage, plus a retired-write counter for debug.

Parameters:
- DATA_W, 32, data width of registers and all data ports.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_out_wb  input  DATA_W  ALU result from the MEM/WB register.
- read_data_wb  input  DATA_W  load data from the MEM/WB register.
- write_reg_wb  input  5  destination register index.
- reg_write_wb  input  1  write enable.
- mem_to_reg_wb  input  3  result source select.
- link_wb  input  1  link write (JAL/JALR/BxxAL).
- pc_plus_4_wb  input  DATA_W  link return address.
- hi_out_wb  input  DATA_W  HI register value.
- lo_out_wb  input  DATA_W  LO register value.
- rd_wb  input  5  rd field; used as the destination when link_wb=1 and rd_wb!=0 (JALR).
- C0_Reg_Data_wb  input  DATA_W  CP0 read data (MFC0).
- rs_addr_d  input  5  read port 1 address.
- rt_addr_d  input  5  read port 2 address.
- rs_data_d  output  DATA_W  read port 1 data.
- rt_data_d  output  DATA_W  read port 2 data.
- result_wb  output  DATA_W  selected write-back value; feeds forwarding.
- wr_count  output  CNT_W  number of committed register writes.

Behaviour:
- Reset (async, rst_n=0): all 32 registers cleared to 0 and wr_count cleared to 0, immediately and independent of clk.
- result_wb is combinational and has no reset value of its own.
- Reset asserted mid-write: the write is lost and registers stay 0 until rst_n deasserts.
- Result select when link_wb=0, by mem_to_reg_wb:
  - 000: alu_out_wb.
  - 001: read_data_wb.
  - 010: hi_out_wb.
  - 011: lo_out_wb.
  - 100: C0_Reg_Data_wb.
  - 101-111: alu_out_wb (default).
- link_wb=1: result_wb = pc_plus_4_wb, regardless of mem_to_reg_wb.
- Destination address:
  - link_wb=1 and rd_wb!=0: rd_wb.
  - link_wb=1 and rd_wb==0: 31.
  - otherwise: write_reg_wb.
- Commit: on the rising clk edge with reg_write_wb=1 and destination!=0, register[dest] <= result_wb and wr_count <= wr_count+1.
  - wr_count wraps modulo 2^CNT_W.
- Writes to r0 are discarded, and wr_count is not incremented for them.
- r0 always reads 0 on both ports.
- Read ports are combinational on rs_addr_d/rt_addr_d and register contents.
- Both ports may read the same address simultaneously; the two outputs are then identical.
- Write latency: the value is visible from storage one edge after commit.
- Same-cycle read/write collision behaviour is defined under Optional Feature.
- Xs on inputs while reg_write_wb=0 must not affect any state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if reg_write_wb=1, dest!=0 and a read address equals dest in the same cycle, that port returns result_wb combinationally (write-through). This removes the need for a half-cycle write.
- Undefined: read ports return stored contents only; a same-cycle collision returns the old value, and the hazard unit must forward result_wb externally.
- Read of r0 returns 0 in both builds.

Test Plan:
- Reset then read all 32 addresses -> every rs_data_d/rt_data_d = 0 and wr_count = 0.
- reg_write_wb=1, write_reg_wb=5, mem_to_reg_wb=001, read_data_wb=0xDEADBEEF, one edge -> reading addr 5 gives 0xDEADBEEF and wr_count=1.
- link_wb=1, rd_wb=0, pc_plus_4_wb=0x00400010, mem_to_reg_wb=011 -> reg31=0x00400010.
- Repeat with rd_wb=7 -> reg7=0x00400010.
- Write 0x12345678 to r0 -> r0 still reads 0 and wr_count unchanged.
- Collision: reg9=0x1, write 0xAAAA5555 to reg9 with rs_addr_d=9 in the same cycle -> rs_data_d=0xAAAA5555 with WB_BYPASS_EN defined, 0x1 without; after the edge, 0xAAAA5555 in both builds.
- Assert rst_n=0 asynchronously between edges after writing reg3=0x55 -> reg3 reads 0 immediately.
- mem_to_reg_wb=100 with C0_Reg_Data_wb=0xC0C0 to reg12 -> reg12=0xC0C0.
- mem_to_reg_wb=110 with alu_out_wb=0x77 -> result_wb=0x77.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: selects the MEM/WB result and commits it into the 32x32 register file.
// Optional macro WB_BYPASS_EN: same-cycle write-through from result_wb to the read ports.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_out_wb,
  input  logic [DATA_W-1:0] read_data_wb,
  input  logic [4:0]        write_reg_wb,
  input  logic              reg_write_wb,
  input  logic [2:0]        mem_to_reg_wb,
  input  logic              link_wb,
  input  logic [DATA_W-1:0] pc_plus_4_wb,
  input  logic [DATA_W-1:0] hi_out_wb,
  input  logic [DATA_W-1:0] lo_out_wb,
  input  logic [4:0]        rd_wb,
  input  logic [DATA_W-1:0] C0_Reg_Data_wb,
  input  logic [4:0]        rs_addr_d,
  input  logic [4:0]        rt_addr_d,
  output logic [DATA_W-1:0] rs_data_d,
  output logic [DATA_W-1:0] rt_data_d,
  output logic [DATA_W-1:0] result_wb,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned AW       = 5;
  localparam int unsigned NREG     = 32;
  localparam logic [AW-1:0] LINK_RA = AW'(31);

  localparam logic [2:0] SEL_ALU = 3'b000;
  localparam logic [2:0] SEL_MEM = 3'b001;
  localparam logic [2:0] SEL_HI  = 3'b010;
  localparam logic [2:0] SEL_LO  = 3'b011;
  localparam logic [2:0] SEL_CP0 = 3'b100;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [AW-1:0]     dest;
  logic              wr_en;

  // Result source select; a link write always returns the link address.
  always_comb begin
    result_wb = alu_out_wb;
    if (link_wb) begin
      result_wb = pc_plus_4_wb;
    end else begin
      unique case (mem_to_reg_wb)
        SEL_ALU: result_wb = alu_out_wb;
        SEL_MEM: result_wb = read_data_wb;
        SEL_HI:  result_wb = hi_out_wb;
        SEL_LO:  result_wb = lo_out_wb;
        SEL_CP0: result_wb = C0_Reg_Data_wb;
        default: result_wb = alu_out_wb;
      endcase
    end
  end

  // JALR names its own link register through rd; the other link forms use ra.
  always_comb begin
    dest = write_reg_wb;
    if (link_wb) begin
      dest = (rd_wb != '0) ? rd_wb : LINK_RA;
    end
  end

  // Writes to r0 are dropped before they reach storage or the counter.
  always_comb begin
    wr_en = 1'b0;
    if (reg_write_wb) begin
      wr_en = (dest != '0);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[dest] <= result_wb;
      end
      cnt_q <= cnt_d;
    end
  end

  assign wr_count = cnt_q;

  always_comb begin
    rs_data_d = '0;
    if (rs_addr_d != '0) begin
`ifdef WB_BYPASS_EN
      rs_data_d = (wr_en && (rs_addr_d == dest)) ? result_wb : regs_q[rs_addr_d];
`else
      rs_data_d = regs_q[rs_addr_d];
`endif
    end
  end

  always_comb begin
    rt_data_d = '0;
    if (rt_addr_d != '0) begin
`ifdef WB_BYPASS_EN
      rt_data_d = (wr_en && (rt_addr_d == dest)) ? result_wb : regs_q[rt_addr_d];
`else
      rt_data_d = regs_q[rt_addr_d];
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a reference model feeds a scoreboard queue that is drained at each check.
module tb_wb_regfile;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] alu_out_wb, read_data_wb, pc_plus_4_wb, hi_out_wb, lo_out_wb, C0_Reg_Data_wb;
  logic [4:0]    write_reg_wb, rd_wb, rs_addr_d, rt_addr_d;
  logic          reg_write_wb, link_wb;
  logic [2:0]    mem_to_reg_wb;
  logic [DW-1:0] rs_data_d, rt_data_d, result_wb;
  logic [DW-1:0] wr_count;

  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] mdl [32];
  logic [DW-1:0] exp_cnt;
  int            tests = 0;
  int            failed = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .alu_out_wb(alu_out_wb), .read_data_wb(read_data_wb),
    .write_reg_wb(write_reg_wb), .reg_write_wb(reg_write_wb),
    .mem_to_reg_wb(mem_to_reg_wb), .link_wb(link_wb),
    .pc_plus_4_wb(pc_plus_4_wb), .hi_out_wb(hi_out_wb), .lo_out_wb(lo_out_wb),
    .rd_wb(rd_wb), .C0_Reg_Data_wb(C0_Reg_Data_wb),
    .rs_addr_d(rs_addr_d), .rt_addr_d(rt_addr_d),
    .rs_data_d(rs_data_d), .rt_data_d(rt_data_d),
    .result_wb(result_wb), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input logic [DW-1:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    tests++;
    if (sb_q.size() == 0) begin
      failed++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Point both read ports at one address and compare against the model.
  task automatic read_chk(input string tag, input logic [4:0] a);
    rs_addr_d = a;
    rt_addr_d = a;
    #1;
    expect_val(mdl[a]);
    check({tag, "_rs"}, rs_data_d);
    expect_val(mdl[a]);
    check({tag, "_rt"}, rt_data_d);
  endtask

  task automatic cnt_chk(input string tag);
    expect_val(exp_cnt);
    check(tag, wr_count);
  endtask

  // Model commit: applied by the bench when it issues an enabled write.
  task automatic model_commit(input logic [4:0] d, input logic [DW-1:0] v);
    if (d != 5'd0) begin
      mdl[d] = v;
      exp_cnt = exp_cnt + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reg_write_wb = 1'b0;
    link_wb      = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_out_wb = '0; read_data_wb = '0; pc_plus_4_wb = '0; hi_out_wb = '0;
    lo_out_wb = '0; C0_Reg_Data_wb = '0; write_reg_wb = '0; rd_wb = '0;
    reg_write_wb = 1'b0; link_wb = 1'b0; mem_to_reg_wb = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    exp_cnt = '0;
  endtask

  initial begin
    idle_inputs();
    rs_addr_d = '0;
    rt_addr_d = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state: every address on both ports, with the ports on different addresses.
    for (int i = 0; i < 32; i++) begin
      rs_addr_d = 5'(i);
      rt_addr_d = 5'(31 - i);
      #1;
      expect_val('0); check($sformatf("reset_rs%0d", i), rs_data_d);
      expect_val('0); check($sformatf("reset_rt%0d", 31 - i), rt_data_d);
    end
    cnt_chk("reset_cnt");

    // Load data into r5.
    reg_write_wb = 1'b1; write_reg_wb = 5'd5; mem_to_reg_wb = 3'b001;
    read_data_wb = 32'hDEADBEEF; alu_out_wb = 32'h0000_1111;
    #1; expect_val(32'hDEADBEEF); check("result_mem", result_wb);
    model_commit(5'd5, 32'hDEADBEEF);
    tick();
    read_chk("r5_load", 5'd5);
    cnt_chk("cnt_after_r5");

    // Link with rd=0 goes to r31 and ignores mem_to_reg/write_reg.
    reg_write_wb = 1'b1; link_wb = 1'b1; rd_wb = 5'd0; write_reg_wb = 5'd4;
    pc_plus_4_wb = 32'h0040_0010; mem_to_reg_wb = 3'b011; lo_out_wb = 32'h2222_3333;
    #1; expect_val(32'h0040_0010); check("result_link", result_wb);
    model_commit(5'd31, 32'h0040_0010);
    tick();
    read_chk("r31_link", 5'd31);
    read_chk("r4_untouched", 5'd4);
    cnt_chk("cnt_after_link31");

    // Link with rd=7 (JALR).
    reg_write_wb = 1'b1; link_wb = 1'b1; rd_wb = 5'd7; write_reg_wb = 5'd4;
    pc_plus_4_wb = 32'h0040_0010; mem_to_reg_wb = 3'b011;
    model_commit(5'd7, 32'h0040_0010);
    tick();
    rd_wb = 5'd0;
    read_chk("r7_link", 5'd7);
    cnt_chk("cnt_after_link7");

    // Write to r0 is discarded.
    reg_write_wb = 1'b1; write_reg_wb = 5'd0; mem_to_reg_wb = 3'b000; alu_out_wb = 32'h1234_5678;
    model_commit(5'd0, 32'h1234_5678);
    tick();
    read_chk("r0_zero", 5'd0);
    cnt_chk("cnt_after_r0");

    // HI and LO sources.
    reg_write_wb = 1'b1; write_reg_wb = 5'd10; mem_to_reg_wb = 3'b010; hi_out_wb = 32'hA1A1_0000;
    model_commit(5'd10, 32'hA1A1_0000);
    tick();
    reg_write_wb = 1'b1; write_reg_wb = 5'd11; mem_to_reg_wb = 3'b011; lo_out_wb = 32'h0000_B2B2;
    model_commit(5'd11, 32'h0000_B2B2);
    tick();
    read_chk("r10_hi", 5'd10);
    read_chk("r11_lo", 5'd11);

    // CP0 source.
    reg_write_wb = 1'b1; write_reg_wb = 5'd12; mem_to_reg_wb = 3'b100; C0_Reg_Data_wb = 32'h0000_C0C0;
    model_commit(5'd12, 32'h0000_C0C0);
    tick();
    read_chk("r12_cp0", 5'd12);

    // Unassigned selects fall back to the ALU result.
    for (int s = 5; s < 8; s++) begin
      reg_write_wb = 1'b1; write_reg_wb = 5'd13; mem_to_reg_wb = 3'(s);
      alu_out_wb = 32'h77 + 32'(s);
      #1; expect_val(32'h77 + 32'(s)); check($sformatf("result_sel%0d", s), result_wb);
      model_commit(5'd13, 32'h77 + 32'(s));
      tick();
    end
    read_chk("r13_default", 5'd13);
    cnt_chk("cnt_after_sel");

    // Same-cycle collision on r9, both ports reading the destination.
    reg_write_wb = 1'b1; write_reg_wb = 5'd9; mem_to_reg_wb = 3'b000; alu_out_wb = 32'h1;
    model_commit(5'd9, 32'h1);
    tick();
    reg_write_wb = 1'b1; write_reg_wb = 5'd9; mem_to_reg_wb = 3'b000; alu_out_wb = 32'hAAAA_5555;
    rs_addr_d = 5'd9; rt_addr_d = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    expect_val(32'hAAAA_5555); check("collide_rs", rs_data_d);
    expect_val(32'hAAAA_5555); check("collide_rt", rt_data_d);
`else
    expect_val(32'h1); check("collide_rs", rs_data_d);
    expect_val(32'h1); check("collide_rt", rt_data_d);
`endif
    model_commit(5'd9, 32'hAAAA_5555);
    tick();
    read_chk("r9_after", 5'd9);

    // Unknown inputs with write disabled leave state untouched.
    alu_out_wb = 'x; read_data_wb = 'x; write_reg_wb = 'x; mem_to_reg_wb = 'x;
    link_wb = 1'b0; rd_wb = 'x; reg_write_wb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    read_chk("r9_x_hold", 5'd9);
    read_chk("r5_x_hold", 5'd5);
    cnt_chk("cnt_x_hold");

    // Async reset between edges, including a write attempted while held.
    reg_write_wb = 1'b1; write_reg_wb = 5'd3; mem_to_reg_wb = 3'b000; alu_out_wb = 32'h55;
    model_commit(5'd3, 32'h55);
    tick();
    read_chk("r3_pre_reset", 5'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    read_chk("r3_async_reset", 5'd3);
    cnt_chk("cnt_async_reset");
    reg_write_wb = 1'b1; write_reg_wb = 5'd3; alu_out_wb = 32'h99;
    tick();
    read_chk("r3_write_in_reset", 5'd3);
    read_chk("r31_in_reset", 5'd31);
    cnt_chk("cnt_in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Operation resumes after reset release.
    reg_write_wb = 1'b1; write_reg_wb = 5'd20; mem_to_reg_wb = 3'b001; read_data_wb = 32'hCAFE_F00D;
    model_commit(5'd20, 32'hCAFE_F00D);
    tick();
    read_chk("r20_post_reset", 5'd20);
    cnt_chk("cnt_post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
